// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  // Arbiter FSM: IDLE picks an owner, XFER streams one locked frame.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DEFAULT_NUM_REQ   = 4;
  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_FRAME_LEN = 8;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus FIFO write port, seen from the arbiter.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_winc;
  logic [WIDTH-1:0]         fifo_wdata;
  logic                     fifo_wfull;
  logic [IDX_W-1:0]         grant_id;
  logic                     busy;
  logic                     frame_done;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_wfull,
    output req_ready, fifo_winc, fifo_wdata, grant_id, busy, frame_done
  );

  // Environment side (producers + FIFO).
  modport master (
    output req_valid, req_data, fifo_wfull,
    input  req_ready, fifo_winc, fifo_wdata, grant_id, busy, frame_done
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Two copies of the request vector let the search run linearly from
  // last_grant+1 up to last_grant+NUM_REQ without explicit wrap logic.
  logic [2*NUM_REQ-1:0] req_dbl;

  assign req_dbl = {req, req};

  // Scan from the farthest offset down so the nearest valid offset wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_dbl[int'(last_grant) + k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-locked round-robin arbiter sharing one FIFO write port.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEFAULT_NUM_REQ,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT      = CNT_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] req_ready;
  logic               beat;
  logic               frame_done;
  logic [WIDTH-1:0]   req_words [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_words
      assign req_words[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt_idx    (pick_idx),
    .gnt_any    (pick_any)
  );

  // Next-state, beat counting and handshake outputs.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    beat         = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        // Only the owner sees ready, and never while the FIFO is full.
        req_ready[grant_id_q] = ~bus.fifo_wfull;
        beat = bus.req_valid[grant_id_q] & ~bus.fifo_wfull;
        if (beat) begin
          if (beat_cnt_q == LAST_BEAT) begin
            frame_done   = 1'b1;
            beat_cnt_d   = '0;
            last_grant_d = grant_id_q;
            state_d      = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.fifo_winc  = beat;
  assign bus.fifo_wdata = req_words[grant_id_q];
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (state_q == ST_XFER);
  assign bus.frame_done = frame_done;

endmodule
